// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART flow-control FIFO.
//   uart_byte_t      : one UART data byte
//   FIFO_MIN_DEPTH   : smallest supported storage depth
//   level_w()        : width of a fill-level value for a given depth
//   fifo_params_ok() : legality check for DEPTH / HI_WATER / LO_WATER
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    localparam int FIFO_MIN_DEPTH = 4;

    // Fill level runs 0..depth inclusive, so it needs one bit more than a pointer.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_params_ok(input int depth, input int hi, input int lo);
        return (depth >= FIFO_MIN_DEPTH) && ((depth & (depth - 1)) == 0) &&
               (lo >= 0) && (lo < hi) && (hi < depth);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port byte storage for uart_flow_fifo.
// Synchronous write, synchronous read with read-enable; the read register
// holds its value while rd_en is low. Contents are never reset.
// Ports:
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request, data appears after the next edge
//   rd_data          : registered read data
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  uart_byte_t               wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output uart_byte_t               rd_data
);

    uart_byte_t mem_q [DEPTH];
    uart_byte_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_flow_fifo.sv
// Byte FIFO between uart_rx and uart_tx with CTS hysteresis and RTS gating.
// The registered read port of the storage acts as the output head
// (first-word fall-through): a byte pushed into an empty FIFO is presented
// after the following edge, and the head is refilled on the same edge it is
// popped, giving 1 byte/cycle sustained.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_data/valid/ready   : write side (from uart_rx)
//   out_data/valid/ready  : read side (to uart_tx)
//   rts_n                 : host ready (0 = ready); no new head loads while 1
//   cts_n                 : clear-to-send to host (0 = go), hysteresis on count
//   fill_level, max_level : only with UART_FLOW_FIFO_STATS_EN defined
module uart_flow_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int HI_WATER = 48,
    parameter int LO_WATER = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  uart_byte_t in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output uart_byte_t out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       rts_n,
    output logic       cts_n
`ifdef UART_FLOW_FIFO_STATS_EN
    ,
    output logic [level_w(DEPTH)-1:0] fill_level,
    output logic [level_w(DEPTH)-1:0] max_level
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [LVL_W-1:0] lvl_t;

    localparam lvl_t DEPTH_L = lvl_t'(DEPTH);
    localparam lvl_t HI_L    = lvl_t'(HI_WATER);
    localparam lvl_t LO_L    = lvl_t'(LO_WATER);

    if (!fifo_params_ok(DEPTH, HI_WATER, LO_WATER)) begin : g_bad_params
        $error("uart_flow_fifo: illegal DEPTH/HI_WATER/LO_WATER combination");
    end

    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    lvl_t       count_q, count_d;
    logic       out_valid_q, out_valid_d;
    logic       stop_q, stop_d;
    logic       push, pop, load;
    uart_byte_t mem_rd_data;

    always_comb begin
        push = in_valid && (count_q != DEPTH_L);
        pop  = out_valid_q && out_ready;
        // count includes the head, so storage holds count - out_valid entries.
        // A new head is fetched when the slot is free (or being vacated) and
        // the host is ready.
        load = (count_q != lvl_t'(out_valid_q)) && !rts_n && (!out_valid_q || out_ready);

        wr_ptr_d    = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        count_d     = count_q + lvl_t'(push) - lvl_t'(pop);
        out_valid_d = load ? 1'b1 : (pop ? 1'b0 : out_valid_q);

        stop_d = stop_q;
        if (count_q >= HI_L)      stop_d = 1'b1;
        else if (count_q <= LO_L) stop_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            stop_q      <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            stop_q      <= stop_d;
        end
    end

    uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_en   (load),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    assign in_ready  = (count_q != DEPTH_L);
    assign out_valid = out_valid_q;
    // Storage read register is not reset; mask it so an empty head reads 0.
    assign out_data  = out_valid_q ? mem_rd_data : '0;
    assign cts_n     = stop_q;

`ifdef UART_FLOW_FIFO_STATS_EN
    lvl_t max_level_q, max_level_d;

    always_comb begin
        max_level_d = (count_q > max_level_q) ? count_q : max_level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) max_level_q <= '0;
        else        max_level_q <= max_level_d;
    end

    assign fill_level = count_q;
    assign max_level  = max_level_q;
`endif

endmodule

// File: tb/tb_uart_flow_fifo.sv
// Scoreboard bench for uart_flow_fifo. Stimulus is driven just after each
// rising edge; a monitor samples on the falling edge, records accepted bytes
// into an expected queue and compares every popped byte, plus flag rules.
module tb_uart_flow_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 64;
    localparam int HI    = 48;
    localparam int LO    = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    uart_byte_t in_data;
    logic       in_valid;
    logic       in_ready;
    uart_byte_t out_data;
    logic       out_valid;
    logic       out_ready;
    logic       rts_n;
    logic       cts_n;
`ifdef UART_FLOW_FIFO_STATS_EN
    logic [6:0] fill_level;
    logic [6:0] max_level;
`endif

    uart_flow_fifo #(.DEPTH(DEPTH), .HI_WATER(HI), .LO_WATER(LO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rts_n     (rts_n),
        .cts_n     (cts_n)
`ifdef UART_FLOW_FIFO_STATS_EN
        ,
        .fill_level(fill_level),
        .max_level (max_level)
`endif
    );

    always #5 clk = ~clk;

    // Controls written only by the stimulus process
    bit stream_mode, stream_done, final_chk;
    int tmo;

    // Monitor / reference model state, written only by the monitor
    int         n_chk, n_fail;
    uart_byte_t sb[$];
    int         mdl_cnt, mdl_max, n_stream;
    bit         mdl_stop;
    bit         ov_p, pop_p, rts_p, first_p1, first_p2, seen_out;
    uart_byte_t od_p;
    bit         push_s, pop_s;

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_data",  int'(out_data), 0);
            chk("rst_cts_n",     int'(cts_n), 1);
            chk("rst_in_ready",  int'(in_ready), 1);
            sb.delete();
            mdl_cnt  = 0;
            mdl_max  = 0;
            mdl_stop = 1'b1;
            ov_p = 0; pop_p = 0; rts_p = 0; first_p1 = 0; first_p2 = 0; seen_out = 0;
        end else begin
            push_s = in_valid && in_ready;
            pop_s  = out_valid && out_ready;

            chk("in_ready", int'(in_ready), int'(mdl_cnt != DEPTH));
            chk("cts_n", int'(cts_n), int'(mdl_stop));
            if (mdl_cnt == 0) chk("empty_out_valid", int'(out_valid), 0);
            if (ov_p && !pop_p) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(od_p));
            end else if (rts_p) begin
                chk("rts_no_load", int'(out_valid), 0);
            end
            if (first_p1) chk("first_not_early", int'(out_valid), 0);
            if (first_p2) chk("first_latency", int'(out_valid), 1);
`ifdef UART_FLOW_FIFO_STATS_EN
            chk("fill_level", int'(fill_level), mdl_cnt);
            chk("max_level", int'(max_level), mdl_max);
`endif
            if (stream_mode && seen_out && mdl_cnt > 0) chk("stream_gap", int'(out_valid), 1);
            if (stream_done) chk("stream_count", n_stream, 200);
            if (final_chk) begin
                chk("timeouts", tmo, 0);
                chk("sb_empty", sb.size(), 0);
            end

            if (pop_s) begin
                if (sb.size() == 0) chk("pop_from_empty", 1, 0);
                else                chk("data", int'(out_data), int'(sb.pop_front()));
                if (stream_mode) begin
                    n_stream++;
                    seen_out = 1;
                end
            end
            if (!stream_mode) seen_out = 0;
            if (push_s) sb.push_back(in_data);

            // Next-cycle expectations from this cycle's fill level
            if (mdl_cnt > mdl_max) mdl_max = mdl_cnt;
            if (mdl_cnt >= HI)      mdl_stop = 1'b1;
            else if (mdl_cnt <= LO) mdl_stop = 1'b0;
            first_p2 = first_p1 && !rts_n;
            first_p1 = (mdl_cnt == 0) && push_s;
            mdl_cnt  = mdl_cnt + int'(push_s) - int'(pop_s);
            ov_p  = out_valid;
            od_p  = out_data;
            pop_p = pop_s;
            rts_p = rts_n;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic push_byte(input uart_byte_t b);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        if (!done) tmo++;
    endtask

    // Wait for the output side to go quiet (callers hold rts_n=0, out_ready=1).
    task automatic wait_drain();
        int quiet = 0;
        for (int t = 0; t < 600 && quiet < 3; t++) begin
            @(negedge clk);
            quiet = out_valid ? 0 : quiet + 1;
        end
        if (quiet < 3) tmo++;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rts_n = 1'b0;
        stream_mode = 0; stream_done = 0; final_chk = 0; tmo = 0;
        idle(3);
        rst_n = 1'b1;

        // Level statistics: push 10, pop 10, push 5
        for (int i = 0; i < 10; i++) push_byte(8'(8'h10 + i));
        out_ready = 1'b1;
        wait_drain();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i));
        idle(3);
        out_ready = 1'b1;
        wait_drain();

        // Single byte into an empty FIFO
        idle(2);
        in_valid = 1'b1; in_data = 8'hA5;
        cyc();
        in_valid = 1'b0;
        idle(4);

        // Fill to full, try to overfill, then drain through the hysteresis band
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) push_byte(8'(i));
        in_valid = 1'b1; in_data = 8'hEE;
        idle(4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Continuous stream, 200 bytes
        stream_mode = 1;
        for (int i = 0; i < 200; i++) push_byte(8'(i * 7 + 3));
        wait_drain();
        stream_mode = 0;
        stream_done = 1;
        cyc();
        stream_done = 0;

        // RTS gating with 3 bytes queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i));
        idle(3);
        rts_n = 1'b1;
        idle(3);
        out_ready = 1'b1;
        idle(4);
        rts_n = 1'b0;
        wait_drain();

        // Reset in the middle of traffic
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data   = 8'($urandom);
            out_ready = (i % 3) != 0;
            cyc();
        end
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // Random traffic: a filling phase then a draining phase
        for (int i = 0; i < 1600; i++) begin
            bit fill_ph = (i % 400) < 250;
            in_valid  = $urandom_range(99, 0) < (fill_ph ? 85 : 20);
            in_data   = 8'($urandom);
            out_ready = $urandom_range(99, 0) < (fill_ph ? 30 : 90);
            rts_n     = $urandom_range(99, 0) < 10;
            cyc();
        end
        in_valid = 1'b0; rts_n = 1'b0; out_ready = 1'b1;
        wait_drain();

        final_chk = 1;
        cyc();
        final_chk = 0;
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
